// File: rtl/dma16_if.sv
// dma16_if: CPU snoop, bus-hold handshake and DMA-side RAM bus of the dma16 engine.
interface dma16_if;
  logic [15:0] cpu_address;
  logic [15:0] cpu_data_out;
  logic        cpu_write;
  logic        hold;
  logic        busy;
  logic [15:0] bus_address;
  logic [15:0] bus_data_in;
  logic [15:0] bus_data_out;
  logic        bus_write;
  logic        bus_owner;

  // DMA engine side
  modport master (
    input  cpu_address, cpu_data_out, cpu_write, busy, bus_data_in,
    output hold, bus_address, bus_data_out, bus_write, bus_owner
  );

  // CPU / RAM / top-level mux side
  modport slave (
    output cpu_address, cpu_data_out, cpu_write, busy, bus_data_in,
    input  hold, bus_address, bus_data_out, bus_write, bus_owner
  );
endinterface

// File: rtl/dma16.sv
// dma16: block-copy DMA engine for the CPU16 bus. Snoops CPU writes to a
// 4-word register window (SRC, DST, COUNT, CTRL), parks the CPU through
// hold/busy, copies COUNT words SRC->DST and hands the bus back.
module dma16 #(
  parameter logic [15:0] BASE_ADDR = 16'h7FF8,
  parameter int unsigned RAM_WAIT  = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  dma16_if.master     bus,
  output logic        active,
  output logic        done,
  output logic [15:0] status
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    WR      = 3'd4,
    NEXT    = 3'd5,
    REL     = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] count_q, count_d;
  logic        src_fixed_q, src_fixed_d;
  logic        dst_fixed_q, dst_fixed_d;
  logic        done_flag_q, done_flag_d;
  logic        hold_q, hold_d;
  logic        bus_owner_q, bus_owner_d;
  logic        bus_write_q, bus_write_d;
  logic [15:0] bus_address_q, bus_address_d;
  logic [15:0] bus_data_out_q, bus_data_out_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  logic        snoop_hit_s;
  logic [15:0] count_dec_s;
  logic [15:0] src_next_s;
  logic [15:0] dst_next_s;

  // Window decode and per-word pointer/count updates (wrap modulo 2^16)
  assign snoop_hit_s = bus.cpu_write && (bus.cpu_address[15:2] == BASE_ADDR[15:2]);
  assign count_dec_s = count_q - 16'd1;
  assign src_next_s  = src_fixed_q ? src_q : (src_q + 16'd1);
  assign dst_next_s  = dst_fixed_q ? dst_q : (dst_q + 16'd1);

  // Next-state, register-window and bus-output logic
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    count_d        = count_q;
    src_fixed_d    = src_fixed_q;
    dst_fixed_d    = dst_fixed_q;
    done_flag_d    = done_flag_q;
    hold_d         = hold_q;
    bus_owner_d    = bus_owner_q;
    bus_write_d    = bus_write_q;
    bus_address_d  = bus_address_q;
    bus_data_out_d = bus_data_out_q;
    active_d       = active_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (snoop_hit_s) begin
          case (bus.cpu_address[1:0])
            2'd0: src_d   = bus.cpu_data_out;
            2'd1: dst_d   = bus.cpu_data_out;
            2'd2: count_d = bus.cpu_data_out;
            2'd3: begin
              src_fixed_d = bus.cpu_data_out[1];
              dst_fixed_d = bus.cpu_data_out[2];
              if (bus.cpu_data_out[0]) begin
                // START: the flag is cleared, then re-set at once for an empty copy
                if (count_q == 16'd0) begin
                  done_d      = 1'b1;
                  done_flag_d = 1'b1;
                end else begin
                  done_flag_d = 1'b0;
                  active_d    = 1'b1;
                  hold_d      = 1'b1;
                  state_d     = REQ;
                end
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // busy counts only while hold is up; a busy left high from CPU reset qualifies
        if (bus.busy && hold_q) begin
          bus_owner_d   = 1'b1;
          bus_address_d = src_q;
          state_d       = RD;
        end else begin
          state_d = REQ;
        end
      end
      RD: begin
        state_d = (RAM_WAIT != 32'd0) ? RD_WAIT : WR;
      end
      RD_WAIT: begin
        state_d = WR;
      end
      WR: begin
        bus_data_out_d = bus.bus_data_in;
        bus_address_d  = dst_q;
        bus_write_d    = 1'b1;
        state_d        = NEXT;
      end
      NEXT: begin
        bus_write_d = 1'b0;
        count_d     = count_dec_s;
        src_d       = src_next_s;
        dst_d       = dst_next_s;
        if (count_dec_s != 16'd0) begin
          bus_address_d = src_next_s;
          state_d       = RD;
        end else begin
          hold_d      = 1'b0;
          bus_owner_d = 1'b0;
          active_d    = 1'b0;
          done_d      = 1'b1;
          done_flag_d = 1'b1;
          state_d     = REL;
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      src_q          <= 16'd0;
      dst_q          <= 16'd0;
      count_q        <= 16'd0;
      src_fixed_q    <= 1'b0;
      dst_fixed_q    <= 1'b0;
      done_flag_q    <= 1'b0;
      hold_q         <= 1'b0;
      bus_owner_q    <= 1'b0;
      bus_write_q    <= 1'b0;
      bus_address_q  <= 16'd0;
      bus_data_out_q <= 16'd0;
      active_q       <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      count_q        <= count_d;
      src_fixed_q    <= src_fixed_d;
      dst_fixed_q    <= dst_fixed_d;
      done_flag_q    <= done_flag_d;
      hold_q         <= hold_d;
      bus_owner_q    <= bus_owner_d;
      bus_write_q    <= bus_write_d;
      bus_address_q  <= bus_address_d;
      bus_data_out_q <= bus_data_out_d;
      active_q       <= active_d;
      done_q         <= done_d;
    end
  end

  assign bus.hold         = hold_q;
  assign bus.bus_owner    = bus_owner_q;
  assign bus.bus_write    = bus_write_q;
  assign bus.bus_address  = bus_address_q;
  assign bus.bus_data_out = bus_data_out_q;
  assign active           = active_q;
  assign done             = done_q;
  assign status           = {done_flag_q, 14'd0, active_q};

endmodule

// File: tb/tb_dma16.sv
// tb_dma16: table-driven copy vectors plus hand-written zero-count and
// mid-transfer reset sequences, against a registered-RAM bus model.
module tb_dma16;
  localparam logic [15:0] BASE = 16'h7FF8;

  logic        clk;
  logic        reset;
  logic        active;
  logic        done;
  logic [15:0] status;

  dma16_if bus_if ();

  dma16 #(.BASE_ADDR(BASE), .RAM_WAIT(32'd1)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .active (active),
    .done   (done),
    .status (status)
  );

  // Registered RAM behind the CPU/DMA mux, with a preload port for the bench
  logic [15:0] mem [0:65535];
  logic [15:0] ram_q;
  logic        pl_we;
  logic [15:0] pl_addr, pl_data;
  logic [15:0] ram_addr_s, ram_wdata_s;
  logic        ram_we_s;

  assign ram_addr_s  = bus_if.bus_owner ? bus_if.bus_address  : bus_if.cpu_address;
  assign ram_wdata_s = bus_if.bus_owner ? bus_if.bus_data_out : bus_if.cpu_data_out;
  assign ram_we_s    = bus_if.bus_owner ? bus_if.bus_write    : bus_if.cpu_write;
  assign bus_if.bus_data_in = ram_q;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we_s) mem[ram_addr_s] <= ram_wdata_s;
    ram_q <= mem[ram_addr_s];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] off, input logic [15:0] d);
    bus_if.cpu_address  = {BASE[15:2], off};
    bus_if.cpu_data_out = d;
    bus_if.cpu_write    = 1'b1;
    @(negedge clk);
    bus_if.cpu_write    = 1'b0;
  endtask

  typedef struct {
    logic [15:0]       src, dst, count, ctrl;
    bit                wr_addrs;
    int                busy_delay;
    int                snoop_at;
    logic [15:0]       pre_addr;
    logic [3:0][15:0]  pre;
    int                n_pre;
    int                n_chk;
    logic [3:0][15:0]  expw;
    int                exp_owned;
    logic [15:0]       exp_last;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int i, input vec_t v);
    int owned, dones, seen, early_bad;
    logic prev_free, hold_at_done;
    logic [15:0] last_rd;
    for (int k = 0; k < v.n_chk; k++) poke(v.dst + 16'(k), 16'h0000);
    for (int k = 0; k < v.n_pre; k++) poke(v.pre_addr + 16'(k), v.pre[k]);
    bus_if.busy = 1'b0;
    if (v.wr_addrs) begin
      cpu_wr(2'd0, v.src);
      cpu_wr(2'd1, v.dst);
    end
    cpu_wr(2'd2, v.count);
    cpu_wr(2'd3, v.ctrl);
    chk($sformatf("v%0d_hold_on_start", i), {15'd0, bus_if.hold}, 16'h0001);
    chk($sformatf("v%0d_status_on_start", i), status, 16'h0001);
    early_bad = 0;
    for (int k = 0; k < v.busy_delay; k++) begin
      if (bus_if.bus_owner || bus_if.bus_write || !bus_if.hold) early_bad = 1;
      if (k == v.snoop_at) begin
        bus_if.cpu_address = BASE; bus_if.cpu_data_out = 16'h0800; bus_if.cpu_write = 1'b1;
      end else begin
        bus_if.cpu_write = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.cpu_write = 1'b0;
    chk($sformatf("v%0d_no_owner_before_busy", i), 16'(early_bad), 16'h0000);
    bus_if.busy = 1'b1;
    owned = 0; dones = 0; seen = 0; prev_free = 1'b1; last_rd = 16'hDEAD; hold_at_done = 1'b1;
    for (int c = 0; c < 300 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_if.bus_owner) owned++;
      if (bus_if.bus_owner && !bus_if.bus_write && prev_free) last_rd = bus_if.bus_address;
      prev_free = !bus_if.bus_owner || bus_if.bus_write;
      if (done) begin dones++; seen = 1; hold_at_done = bus_if.hold; end
    end
    chk($sformatf("v%0d_done_seen", i), 16'(seen), 16'h0001);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk($sformatf("v%0d_done_pulses", i), 16'(dones), 16'h0001);
    chk($sformatf("v%0d_owned_cycles", i), 16'(owned), 16'(v.exp_owned));
    chk($sformatf("v%0d_last_read_addr", i), last_rd, v.exp_last);
    chk($sformatf("v%0d_hold_at_done", i), {15'd0, hold_at_done}, 16'h0000);
    chk($sformatf("v%0d_status_end", i), status, 16'h8000);
    for (int k = 0; k < v.n_chk; k++)
      chk($sformatf("v%0d_ram_dst%0d", i, k), mem[v.dst + 16'(k)], v.expw[k]);
    bus_if.busy = 1'b0;
    @(negedge clk);
  endtask

  // Watchdog so the run always ends
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    //        src       dst       count  ctrl     wr delay snoop pre_addr  pre                                      npre nchk expw                                     owned last
    vecs[0] = '{16'h0100, 16'h0200, 16'd4, 16'h0001, 1'b1, 1, -1, 16'h0100, {16'h4444,16'h3333,16'h2222,16'h1111}, 4, 4, {16'h4444,16'h3333,16'h2222,16'h1111}, 16, 16'h0103};
    vecs[1] = '{16'h0050, 16'h0300, 16'd3, 16'h0003, 1'b1, 1, -1, 16'h0050, {16'h0000,16'h5252,16'h5151,16'hABCD}, 3, 3, {16'h0000,16'hABCD,16'hABCD,16'hABCD}, 12, 16'h0050};
    vecs[2] = '{16'hFFFE, 16'h0010, 16'd3, 16'h0001, 1'b1, 1, -1, 16'hFFFE, {16'h0000,16'hF000,16'hF00F,16'hF00E}, 3, 3, {16'h0000,16'hF000,16'hF00F,16'hF00E}, 12, 16'h0000};
    vecs[3] = '{16'h0001, 16'h0013, 16'd1, 16'h0001, 1'b0, 1, -1, 16'h0001, {16'h0000,16'h0000,16'h0000,16'h1001}, 1, 1, {16'h0000,16'h0000,16'h0000,16'h1001},  4, 16'h0001};
    vecs[4] = '{16'h0400, 16'h0500, 16'd2, 16'h0005, 1'b1, 1, -1, 16'h0400, {16'h0000,16'h0000,16'h4001,16'h4000}, 2, 2, {16'h0000,16'h0000,16'h0000,16'h4001},  8, 16'h0401};
    vecs[5] = '{16'h0600, 16'h0700, 16'd2, 16'h0001, 1'b1, 5,  2, 16'h0600, {16'h0000,16'h0000,16'h6001,16'h6000}, 2, 2, {16'h0000,16'h0000,16'h6001,16'h6000},  8, 16'h0601};

    reset = 1'b0;
    pl_we = 1'b0; pl_addr = 16'h0000; pl_data = 16'h0000;
    bus_if.cpu_address = 16'h0000; bus_if.cpu_data_out = 16'h0000;
    bus_if.cpu_write = 1'b0; bus_if.busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_hold", {15'd0, bus_if.hold}, 16'h0000);
    chk("reset_owner_write", {14'd0, bus_if.bus_owner, bus_if.bus_write}, 16'h0000);
    chk("reset_active_done", {14'd0, active, done}, 16'h0000);
    chk("reset_status", status, 16'h0000);
    chk("reset_bus_address", bus_if.bus_address, 16'h0000);
    chk("reset_bus_data_out", bus_if.bus_data_out, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    poke(16'h0800, 16'h8888);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Zero count: no hold, done on the following cycle only
    cpu_wr(2'd2, 16'h0000);
    cpu_wr(2'd3, 16'h0001);
    chk("zero_done", {15'd0, done}, 16'h0001);
    chk("zero_hold", {15'd0, bus_if.hold}, 16'h0000);
    chk("zero_status", status, 16'h8000);
    @(negedge clk);
    chk("zero_done_single", {15'd0, done}, 16'h0000);
    chk("zero_hold_after", {14'd0, bus_if.hold, active}, 16'h0000);

    // Reset mid-transfer after the second word has been written
    for (int k = 0; k < 4; k++) poke(16'h0900 + 16'(k), 16'h9000 + 16'(k));
    for (int k = 0; k < 4; k++) poke(16'h0A00 + 16'(k), 16'h0000);
    bus_if.busy = 1'b1;
    cpu_wr(2'd0, 16'h0900);
    cpu_wr(2'd1, 16'h0A00);
    cpu_wr(2'd2, 16'h0004);
    cpu_wr(2'd3, 16'h0001);
    writes = 0;
    for (int c = 0; c < 100 && writes < 2; c++) begin
      @(negedge clk);
      if (bus_if.bus_write) writes++;
    end
    chk("rst_two_writes_seen", 16'(writes), 16'h0002);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hold_drop", {15'd0, bus_if.hold}, 16'h0000);
    chk("rst_owner_write_drop", {14'd0, bus_if.bus_owner, bus_if.bus_write}, 16'h0000);
    chk("rst_status", status, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    bus_if.busy = 1'b0;
    @(negedge clk);
    chk("rst_ram_w0", mem[16'h0A00], 16'h9000);
    chk("rst_ram_w1", mem[16'h0A01], 16'h9001);
    chk("rst_ram_w2_untouched", mem[16'h0A02], 16'h0000);
    chk("rst_bus_address", bus_if.bus_address, 16'h0000);
    // COUNT came back as zero, so a bare START completes without a hold
    cpu_wr(2'd3, 16'h0001);
    chk("rst_count_zero_done", {15'd0, done}, 16'h0001);
    chk("rst_count_zero_hold", {15'd0, bus_if.hold}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
